emu_ctrl_seq: RTL and testbench

- Command-driven sequencer for the emulator run/stall controls.
- Accepts queued host or testbench commands (run, stall, run-until, run-for) and drives emu_ctrl_mode/emu_ctrl_data into the emulator time manager.
- Monitors emu_time to retire timed commands; replaces the hand-written sim_ctrl used in simulation mode.
- Also usable on FPGA behind a register bridge.

---
 rtl/emu_ctrl_seq.sv | 156 +++++++++++++++
 tb/tb_emu_ctrl_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_ctrl_seq.sv
// Command sequencer for the emulator run/stall controls: queues run, stall,
// run-until and run-for commands and drives emu_ctrl_mode/emu_ctrl_data.
module emu_ctrl_seq #(
  parameter int TIME_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  emu_clk,
  input  logic                  emu_rst,
  input  logic [TIME_WIDTH-1:0] emu_time,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [TIME_WIDTH-1:0] cmd_data,
  output logic [1:0]            emu_ctrl_mode,
  output logic [TIME_WIDTH-1:0] emu_ctrl_data,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [CNT_WIDTH-1:0]  fifo_level,
  output logic                  overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  localparam logic [1:0] OP_RUN       = 2'd0;
  localparam logic [1:0] OP_STALL     = 2'd1;
  localparam logic [1:0] OP_RUN_UNTIL = 2'd2;
  localparam logic [1:0] OP_RUN_FOR   = 2'd3;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_STALL = 2'd1;
  localparam logic [1:0] MODE_UNTIL = 2'd2;

  logic [1:0]            state;
  logic [1:0]            q_op   [FIFO_DEPTH];
  logic [TIME_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic [1:0]            cur_op;
  logic [TIME_WIDTH-1:0] cur_data;
  logic [TIME_WIDTH:0]   run_for_sum;
  logic [TIME_WIDTH-1:0] target;
  logic                  target_reached;

  assign cmd_ready = (fifo_level < CNT_WIDTH'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && (fifo_level != '0);
  assign busy      = (state == ST_ARMED);

  // Relative targets saturate rather than wrap so a huge run-for never ends early.
  assign run_for_sum    = {1'b0, emu_time} + {1'b0, cur_data};
  assign target         = (cur_op == OP_RUN_FOR)
                          ? (run_for_sum[TIME_WIDTH] ? '1 : run_for_sum[TIME_WIDTH-1:0])
                          : cur_data;
  assign target_reached = (target <= emu_time);

  always_ff @(posedge emu_clk) begin
    if (push) begin
      q_op[wr_ptr]   <= cmd_op;
      q_data[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + CNT_WIDTH'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - CNT_WIDTH'(1);
      end
      if (cmd_valid && !cmd_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Retiring always lands in IDLE, so done_pulse can never fire twice in a row.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state         <= ST_IDLE;
      emu_ctrl_mode <= MODE_STALL;
      emu_ctrl_data <= '0;
      done_pulse    <= 1'b0;
      cur_op        <= OP_RUN;
      cur_data      <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_op   <= q_op[rd_ptr];
            cur_data <= q_data[rd_ptr];
            state    <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          case (cur_op)
            OP_RUN: begin
              emu_ctrl_mode <= MODE_FREE;
              emu_ctrl_data <= '0;
              done_pulse    <= 1'b1;
              state         <= ST_IDLE;
            end
            OP_STALL: begin
              emu_ctrl_mode <= MODE_STALL;
              emu_ctrl_data <= '0;
              done_pulse    <= 1'b1;
              state         <= ST_IDLE;
            end
            default: begin
              if (target_reached) begin
                emu_ctrl_mode <= MODE_STALL;
                emu_ctrl_data <= '0;
                done_pulse    <= 1'b1;
                state         <= ST_IDLE;
              end else begin
                emu_ctrl_mode <= MODE_UNTIL;
                emu_ctrl_data <= target;
                state         <= ST_ARMED;
              end
            end
          endcase
        end
        ST_ARMED: begin
          if (emu_time >= emu_ctrl_data) begin
            emu_ctrl_mode <= MODE_STALL;
            emu_ctrl_data <= '0;
            done_pulse    <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emu_ctrl_seq.sv
// Scoreboard bench for emu_ctrl_seq: directed commands queue their expected
// retire values, and a monitor checks each done_pulse against the queue.
module tb_emu_ctrl_seq;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        emu_clk = 1'b0;
  logic        emu_rst = 1'b1;
  logic [63:0] emu_time = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [63:0] cmd_data = '0;
  logic [1:0]  emu_ctrl_mode;
  logic [63:0] emu_ctrl_data;
  logic        busy;
  logic        done_pulse;
  logic [2:0]  fifo_level;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   prev_done = 1'b0;
  exp_t sb[$];

  emu_ctrl_seq #(.TIME_WIDTH(64), .FIFO_DEPTH(4), .CNT_WIDTH(3)) dut (
    .emu_clk(emu_clk),
    .emu_rst(emu_rst),
    .emu_time(emu_time),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .emu_ctrl_mode(emu_ctrl_mode),
    .emu_ctrl_data(emu_ctrl_data),
    .busy(busy),
    .done_pulse(done_pulse),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 emu_clk = ~emu_clk;

  always @(posedge emu_clk) cyc <= cyc + 1;

  // Each retire must match the oldest expected response, and never repeat back-to-back.
  always @(negedge emu_clk) begin
    exp_t e;
    if (!emu_rst) begin
      if (done_pulse) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("[TB] FAIL done_pulse_double: got two consecutive pulses at cycle %0d, required single", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_retire: got done_pulse at cycle %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (emu_ctrl_mode !== e.mode) begin
            errors++;
            $display("[TB] FAIL retire_mode: got %0d required %0d (cycle %0d)", emu_ctrl_mode, e.mode, cyc);
          end
          checks++;
          if (emu_ctrl_data !== e.data) begin
            errors++;
            $display("[TB] FAIL retire_data: got %0h required %0h (cycle %0d)", emu_ctrl_data, e.data, cyc);
          end
          if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("[TB] FAIL retire_latency: got cycle %0d required cycle %0d", cyc, e.cyc);
            end
          end
        end
      end
      prev_done = done_pulse;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; holds the command for exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] data,
                               input bit exp_en, input logic [1:0] exp_mode,
                               input logic [63:0] exp_data, input bit timed);
    exp_t e;
    if (exp_en) begin
      e.mode = exp_mode;
      e.data = exp_data;
      e.cyc  = timed ? cyc + 3 : -1;
      sb.push_back(e);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge emu_clk);
    @(negedge emu_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge emu_clk);
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge emu_clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d responses outstanding required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge emu_clk);
    emu_rst = 1'b0;
    waitCycles(6);
    checkOutput("reset_mode", 64'(emu_ctrl_mode), 64'd1);
    checkOutput("reset_data", emu_ctrl_data, 64'd0);
    checkOutput("reset_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset_level", 64'(fifo_level), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);

    applyStimulus(2'd0, 64'd0, 1'b1, 2'd0, 64'd0, 1'b1);
    waitCycles(3);
    checkOutput("run_mode", 64'(emu_ctrl_mode), 64'd0);
    applyStimulus(2'd1, 64'd0, 1'b1, 2'd1, 64'd0, 1'b1);
    waitDrain("stall_drain", 10);

    emu_time = 64'd100;
    applyStimulus(2'd3, 64'd50, 1'b1, 2'd1, 64'd0, 1'b0);
    waitCycles(2);
    checkOutput("runfor_mode", 64'(emu_ctrl_mode), 64'd2);
    checkOutput("runfor_data", emu_ctrl_data, 64'd150);
    checkOutput("runfor_busy", 64'(busy), 64'd1);
    for (int t = 101; t <= 149; t++) begin
      emu_time = 64'(t);
      @(negedge emu_clk);
    end
    checkOutput("runfor_still_busy", 64'(busy), 64'd1);
    emu_time = 64'd150;
    @(negedge emu_clk);
    checkOutput("runfor_done_mode", 64'(emu_ctrl_mode), 64'd1);
    checkOutput("runfor_done_busy", 64'(busy), 64'd0);
    waitDrain("runfor_drain", 5);

    emu_time = 64'd30;
    applyStimulus(2'd0, 64'd0, 1'b1, 2'd0, 64'd0, 1'b1);
    waitCycles(2);
    applyStimulus(2'd2, 64'd20, 1'b1, 2'd1, 64'd0, 1'b1);
    waitCycles(2);
    checkOutput("until_past_busy", 64'(busy), 64'd0);
    waitDrain("until_past_drain", 10);

    emu_time = 64'd500;
    applyStimulus(2'd0, 64'd0, 1'b1, 2'd0, 64'd0, 1'b1);
    waitCycles(2);
    applyStimulus(2'd2, 64'd500, 1'b1, 2'd1, 64'd0, 1'b1);
    waitCycles(2);
    applyStimulus(2'd2, 64'd501, 1'b1, 2'd1, 64'd0, 1'b0);
    waitCycles(2);
    checkOutput("until_next_data", emu_ctrl_data, 64'd501);
    checkOutput("until_next_busy", 64'(busy), 64'd1);
    emu_time = 64'd501;
    waitDrain("until_next_drain", 10);

    emu_time = 64'hFFFF_FFFF_FFFF_FFFC;
    applyStimulus(2'd3, 64'd8, 1'b1, 2'd1, 64'd0, 1'b0);
    waitCycles(2);
    checkOutput("sat_mode", 64'(emu_ctrl_mode), 64'd2);
    checkOutput("sat_data", emu_ctrl_data, 64'hFFFF_FFFF_FFFF_FFFF);
    emu_time = 64'hFFFF_FFFF_FFFF_FFFF;
    waitDrain("sat_drain", 10);
    applyStimulus(2'd0, 64'd0, 1'b1, 2'd0, 64'd0, 1'b1);
    waitCycles(2);
    applyStimulus(2'd3, 64'd0, 1'b1, 2'd1, 64'd0, 1'b1);
    waitDrain("runfor_zero_drain", 10);

    emu_time = 64'd1000;
    applyStimulus(2'd2, 64'd2000, 1'b1, 2'd1, 64'd0, 1'b0);
    waitCycles(2);
    applyStimulus(2'd0, 64'd0, 1'b1, 2'd0, 64'd0, 1'b0);
    applyStimulus(2'd1, 64'd0, 1'b1, 2'd1, 64'd0, 1'b0);
    applyStimulus(2'd0, 64'd0, 1'b1, 2'd0, 64'd0, 1'b0);
    applyStimulus(2'd2, 64'd1500, 1'b1, 2'd1, 64'd0, 1'b0);
    checkOutput("full_ready", 64'(cmd_ready), 64'd0);
    checkOutput("full_level", 64'(fifo_level), 64'd4);
    checkOutput("full_no_overflow", 64'(overflow), 64'd0);
    applyStimulus(2'd0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b0);
    checkOutput("overflow_set", 64'(overflow), 64'd1);
    checkOutput("overflow_level", 64'(fifo_level), 64'd4);
    emu_time = 64'd2000;
    waitDrain("overflow_drain", 40);
    checkOutput("overflow_sticky", 64'(overflow), 64'd1);
    checkOutput("drained_level", 64'(fifo_level), 64'd0);

    emu_time = 64'd10;
    applyStimulus(2'd2, 64'd100, 1'b0, 2'd0, 64'd0, 1'b0);
    waitCycles(2);
    applyStimulus(2'd0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b0);
    applyStimulus(2'd0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b0);
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    checkOutput("pre_reset_level", 64'(fifo_level), 64'd2);
    emu_rst = 1'b1;
    #1;
    checkOutput("abort_mode", 64'(emu_ctrl_mode), 64'd1);
    checkOutput("abort_data", emu_ctrl_data, 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_level", 64'(fifo_level), 64'd0);
    checkOutput("abort_overflow", 64'(overflow), 64'd0);
    @(negedge emu_clk);
    emu_rst = 1'b0;
    emu_time = 64'd1000;
    waitCycles(8);
    checkOutput("post_reset_mode", 64'(emu_ctrl_mode), 64'd1);
    applyStimulus(2'd0, 64'd0, 1'b1, 2'd0, 64'd0, 1'b1);
    waitDrain("post_reset_drain", 10);
    waitCycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
